// File: rtl/pe_array_ctrl.sv
// rtl/pe_array_ctrl.sv - tile sequencer for the broadcast-weight MAC array
// Issues operand reads, clear/enable strobes and the per-tile result handshake.
module pe_array_ctrl #(
    parameter int ADDR_W = 12,
    parameter int K_W    = 8,
    parameter int T_W    = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [K_W-1:0]    cfg_k_len,
    input  logic [T_W-1:0]    cfg_tile_num,
    input  logic [ADDR_W-1:0] cfg_act_base,
    input  logic [ADDR_W-1:0] cfg_wet_base,
    input  logic [7:0]        cfg_shift,
    output logic              act_rd_en,
    output logic [ADDR_W-1:0] act_rd_addr,
    output logic              wet_rd_en,
    output logic [ADDR_W-1:0] wet_rd_addr,
    output logic              PE_mac_enable,
    output logic              PE_clear_acc,
    output logic [7:0]        PE_res_shift_num,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [T_W-1:0]    res_tile_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [K_W:0]      cyc;
    logic [T_W-1:0]    t;
    logic [K_W-1:0]    k_len;
    logic [T_W-1:0]    tile_num;
    logic [ADDR_W-1:0] act_base;
    logic [ADDR_W-1:0] wet_tile_base;
    logic [7:0]        shift;

    logic [K_W:0]      k_ext;
    logic [K_W:0]      k_end;
    logic              last_tile;
    logic              rd_cycle;

    // cyc is one bit wider than K so that K+1 is representable for K = 2^K_W-1
    assign k_ext     = {1'b0, k_len};
    assign k_end     = k_ext + (K_W+1)'(1);
    assign last_tile = (t == tile_num - T_W'(1));
    assign rd_cycle  = (state == S_RUN) && (cyc < k_ext);

    assign PE_res_shift_num = shift;

    always_comb begin
        state_next    = state;
        act_rd_en     = 1'b0;
        wet_rd_en     = 1'b0;
        act_rd_addr   = '0;
        wet_rd_addr   = '0;
        PE_mac_enable = 1'b0;
        PE_clear_acc  = 1'b0;
        res_valid     = 1'b0;
        res_tile_idx  = '0;
        busy          = (state != S_IDLE);
        done          = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (cfg_k_len == '0 || cfg_tile_num == '0) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                act_rd_en     = rd_cycle;
                wet_rd_en     = rd_cycle;
                PE_clear_acc  = (cyc == '0);
                PE_mac_enable = (cyc != '0);
                if (rd_cycle) begin
                    act_rd_addr = act_base + ADDR_W'(cyc);
                    wet_rd_addr = wet_tile_base + ADDR_W'(cyc);
                end
                if (cyc == k_end) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_next = S_OUT;
            end
            S_OUT: begin
                res_valid    = 1'b1;
                res_tile_idx = t;
                if (res_ready) begin
                    state_next = last_tile ? S_DONE : S_RUN;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            cyc           <= '0;
            t             <= '0;
            k_len         <= '0;
            tile_num      <= '0;
            act_base      <= '0;
            wet_tile_base <= '0;
            shift         <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k_len         <= cfg_k_len;
                        tile_num      <= cfg_tile_num;
                        act_base      <= cfg_act_base;
                        wet_tile_base <= cfg_wet_base;
                        shift         <= cfg_shift;
                        cyc           <= '0;
                        t             <= '0;
                    end
                end
                S_RUN: begin
                    cyc <= (state_next == S_RUN) ? cyc + (K_W+1)'(1) : '0;
                end
                S_OUT: begin
                    // weight base advances by K per tile and wraps with the address width
                    if (res_ready && !last_tile) begin
                        t             <= t + T_W'(1);
                        wet_tile_base <= wet_tile_base + ADDR_W'(k_len);
                        cyc           <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb/tb_pe_array_ctrl.sv - directed bench for pe_array_ctrl with a small MAC array model
module tb_pe_array_ctrl;

    localparam int ADDR_W = 12;
    localparam int K_W    = 8;
    localparam int T_W    = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [K_W-1:0]    cfg_k_len;
    logic [T_W-1:0]    cfg_tile_num;
    logic [ADDR_W-1:0] cfg_act_base;
    logic [ADDR_W-1:0] cfg_wet_base;
    logic [7:0]        cfg_shift;
    logic              act_rd_en;
    logic [ADDR_W-1:0] act_rd_addr;
    logic              wet_rd_en;
    logic [ADDR_W-1:0] wet_rd_addr;
    logic              PE_mac_enable;
    logic              PE_clear_acc;
    logic [7:0]        PE_res_shift_num;
    logic              res_valid;
    logic              res_ready;
    logic [T_W-1:0]    res_tile_idx;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pe_array_ctrl #(.ADDR_W(ADDR_W), .K_W(K_W), .T_W(T_W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .cfg_k_len        (cfg_k_len),
        .cfg_tile_num     (cfg_tile_num),
        .cfg_act_base     (cfg_act_base),
        .cfg_wet_base     (cfg_wet_base),
        .cfg_shift        (cfg_shift),
        .act_rd_en        (act_rd_en),
        .act_rd_addr      (act_rd_addr),
        .wet_rd_en        (wet_rd_en),
        .wet_rd_addr      (wet_rd_addr),
        .PE_mac_enable    (PE_mac_enable),
        .PE_clear_acc     (PE_clear_acc),
        .PE_res_shift_num (PE_res_shift_num),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_tile_idx     (res_tile_idx),
        .busy             (busy),
        .done             (done)
    );

    // One lane of the array: activation SRAM returns 2, weight SRAM returns addr[1:0]+1
    logic signed [7:0]  act_data, wet_data, act_q, wet_q, arr_out;
    logic signed [19:0] acc, prod;
    logic               clr_d;

    assign prod = act_q * wet_q;

    function automatic logic signed [7:0] sat8(input logic signed [19:0] v);
        if (v > 20'sd127)       return 8'sd127;
        else if (v < -20'sd128) return -8'sd128;
        else                    return v[7:0];
    endfunction

    always @(posedge clk) begin
        act_data <= act_rd_en ? 8'sd2 : 8'sd0;
        wet_data <= wet_rd_en ? $signed({6'd0, wet_rd_addr[1:0]} + 8'd1) : 8'sd0;
        act_q    <= act_data;
        wet_q    <= wet_data;
        clr_d    <= PE_clear_acc;
        if (PE_mac_enable) acc <= clr_d ? 20'sd0 : acc + prod;
        else               arr_out <= sat8(acc >>> PE_res_shift_num);
    end

    function automatic logic [6:0] flags();
        return {act_rd_en, wet_rd_en, PE_clear_acc, PE_mac_enable, res_valid, done, busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [7:0] k, input logic [7:0] n,
                             input logic [11:0] a, input logic [11:0] w, input logic [7:0] sh);
        cfg_k_len    = k;
        cfg_tile_num = n;
        cfg_act_base = a;
        cfg_wet_base = w;
        cfg_shift    = sh;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    task automatic run_t1(input string p);
        logic [6:0]  ef [9];
        logic [11:0] ea [9];
        logic [11:0] ew [9];
        ef = '{7'b1110001, 7'b1101001, 7'b1101001, 7'b0001001, 7'b0001001,
               7'b0000001, 7'b0000101, 7'b0000011, 7'b0000000};
        ea = '{12'h010, 12'h011, 12'h012, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0};
        ew = '{12'h020, 12'h021, 12'h022, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0};
        res_ready = 1'b1;
        start_job(8'd3, 8'd1, 12'h010, 12'h020, 8'd0);
        for (int c = 0; c < 9; c++) begin
            chk($sformatf("%s_flags_c%0d", p, c + 1), 32'(flags()), 32'(ef[c]));
            chk($sformatf("%s_act_addr_c%0d", p, c + 1), 32'(act_rd_addr), 32'(ea[c]));
            chk($sformatf("%s_wet_addr_c%0d", p, c + 1), 32'(wet_rd_addr), 32'(ew[c]));
            if (c == 6) begin
                chk({p, "_tile_idx"}, 32'(res_tile_idx), 32'd0);
                chk({p, "_result"}, 32'(arr_out), 32'd12);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        res_ready    = 1'b0;
        cfg_k_len    = '0;
        cfg_tile_num = '0;
        cfg_act_base = '0;
        cfg_wet_base = '0;
        cfg_shift    = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_flags", 32'(flags()), 32'd0);
        chk("reset_addrs", {8'd0, act_rd_addr, wet_rd_addr}, 32'd0);
        chk("reset_shift_idx", {16'd0, PE_res_shift_num, res_tile_idx}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // basic single tile, K=3
        run_t1("t1");

        // K=4, three tiles, writeback stalls for 5 cycles on tile 1
        res_ready = 1'b1;
        start_job(8'd4, 8'd3, 12'h100, 12'h200, 8'd1);
        for (int c = 1; c <= 31; c++) begin
            if (c == 1) begin
                chk("t3_act_first", 32'(act_rd_addr), 32'h100);
                chk("t3_wet_first", 32'(wet_rd_addr), 32'h200);
            end
            if (c == 8) begin
                chk("t3_tile0_valid", {31'd0, res_valid}, 32'd1);
                chk("t3_tile0_idx", 32'(res_tile_idx), 32'd0);
                chk("t3_tile0_result", 32'(arr_out), 32'd10);
            end
            if (c == 9) begin
                chk("t3_tile1_wet", 32'(wet_rd_addr), 32'h204);
                chk("t3_tile1_act", 32'(act_rd_addr), 32'h100);
            end
            if (c >= 16 && c <= 21) begin
                chk($sformatf("t3_stall_valid_c%0d", c), {31'd0, res_valid}, 32'd1);
                chk($sformatf("t3_stall_idx_c%0d", c), 32'(res_tile_idx), 32'd1);
                chk($sformatf("t3_stall_mac_c%0d", c), {31'd0, PE_mac_enable}, 32'd0);
                chk($sformatf("t3_stall_result_c%0d", c), 32'(arr_out), 32'd10);
            end
            if (c == 22) begin
                chk("t3_tile2_wet", 32'(wet_rd_addr), 32'h208);
                chk("t3_tile2_flags", 32'(flags()), 32'b1110001);
            end
            if (c == 29) chk("t3_tile2_idx", 32'(res_tile_idx), 32'd2);
            if (c == 30) chk("t3_done", 32'(flags()), 32'b0000011);
            if (c == 31) chk("t3_idle", 32'(flags()), 32'd0);
            if (c == 15) res_ready = 1'b0;
            if (c == 21) res_ready = 1'b1;
            @(negedge clk);
        end

        // degenerate jobs finish immediately with no reads or enables
        start_job(8'd0, 8'd2, 12'h010, 12'h020, 8'd5);
        chk("k0_done", 32'(flags()), 32'b0000011);
        @(negedge clk);
        chk("k0_idle", 32'(flags()), 32'd0);
        chk("k0_shift_held", 32'(PE_res_shift_num), 32'd5);
        start_job(8'd5, 8'd0, 12'h010, 12'h020, 8'd6);
        chk("n0_done", 32'(flags()), 32'b0000011);
        @(negedge clk);
        chk("n0_idle", 32'(flags()), 32'd0);

        // weight address wrap, and a start while busy is ignored
        start_job(8'd4, 8'd1, 12'h7FF, 12'hFFE, 8'd2);
        for (int c = 1; c <= 10; c++) begin
            if (c == 1) chk("wrap_c1", {8'd0, act_rd_addr, wet_rd_addr}, {8'd0, 12'h7FF, 12'hFFE});
            if (c == 2) chk("wrap_c2", {8'd0, act_rd_addr, wet_rd_addr}, {8'd0, 12'h800, 12'hFFF});
            if (c == 3) begin
                chk("wrap_c3", {8'd0, act_rd_addr, wet_rd_addr}, {8'd0, 12'h801, 12'h000});
                chk("ign_shift", 32'(PE_res_shift_num), 32'd2);
            end
            if (c == 4) chk("wrap_c4", {8'd0, act_rd_addr, wet_rd_addr}, {8'd0, 12'h802, 12'h001});
            if (c == 5) chk("wrap_c5", 32'(flags()), 32'b0001001);
            if (c == 8) chk("wrap_c8_no_done", {31'd0, done}, 32'd0);
            if (c == 9) chk("wrap_done", 32'(flags()), 32'b0000011);
            if (c == 10) begin
                chk("wrap_idle", 32'(flags()), 32'd0);
                chk("wrap_shift_idle", 32'(PE_res_shift_num), 32'd2);
            end
            start = (c == 2);
            if (c == 2) begin
                cfg_k_len    = 8'd9;
                cfg_tile_num = 8'd2;
                cfg_act_base = 12'h456;
                cfg_wet_base = 12'h123;
                cfg_shift    = 8'd7;
            end
            @(negedge clk);
        end

        // asynchronous reset mid-RUN, then a clean job
        start_job(8'd3, 8'd1, 12'h010, 12'h020, 8'd3);
        @(negedge clk);
        @(negedge clk);
        chk("abort_pre", 32'(act_rd_addr), 32'h012);
        reset_n = 1'b0;
        #1;
        chk("abort_flags", 32'(flags()), 32'd0);
        chk("abort_addrs", {8'd0, act_rd_addr, wet_rd_addr}, 32'd0);
        chk("abort_shift", 32'(PE_res_shift_num), 32'd0);
        @(negedge clk);
        chk("abort_no_done", {31'd0, done}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        run_t1("rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_array_ctrl.md
Name: pe_array_ctrl

Overview:
Sequencer for the MAC-array datapath: MAC_NUM signed 8-bit lanes with one broadcast weight, 1-cycle input registers, 1-cycle-delayed clear, and a registered saturating output. On a start pulse it runs cfg_tile_num output tiles of cfg_k_len MAC steps each. For every tile it issues activation/weight buffer reads, drives PE_mac_enable, PE_clear_acc and PE_res_shift_num, then presents a result-valid/ready handshake to the writeback stage. It sits between the top-level layer controller and the MAC array and its operand SRAMs.

Parameters:
ADDR_W, 12, width of activation and weight buffer read addresses
K_W, 8, width of cfg_k_len (MAC steps per tile)
T_W, 8, width of cfg_tile_num and tile index

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  1-cycle pulse; accepted only in IDLE
cfg_k_len  input  K_W  MAC steps per tile; sampled on accepted start
cfg_tile_num  input  T_W  tiles per job; sampled on start
cfg_act_base  input  ADDR_W  activation base address; sampled on start
cfg_wet_base  input  ADDR_W  weight base address; sampled on start
cfg_shift  input  8  result shift amount; sampled on start
act_rd_en  output  1  activation buffer read enable (data returns next cycle)
act_rd_addr  output  ADDR_W  activation read address
wet_rd_en  output  1  weight buffer read enable (data returns next cycle)
wet_rd_addr  output  ADDR_W  weight read address
PE_mac_enable  output  1  to array
PE_clear_acc  output  1  to array
PE_res_shift_num  output  8  to array; equals latched cfg_shift
res_valid  output  1  array result outputs hold the current tile's result
res_ready  input  1  writeback accepts the result
res_tile_idx  output  T_W  index of the tile being presented
busy  output  1  high in every state except IDLE
done  output  1  1-cycle pulse at job end

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters and latched configuration 0. Reset asserted mid-job aborts immediately. No done pulse is produced. The array is not cleared; the next tile's clear cycle handles that.
- States: IDLE, RUN, DRAIN, OUT, DONE. A cycle counter cyc counts 0..K+1 in RUN, where K is the latched cfg_k_len. Tile counter t runs 0..tile_num-1.
- IDLE: on start, latch the configuration.
  - If cfg_k_len==0 or cfg_tile_num==0, go to DONE. No reads and no enables are issued.
  - Otherwise go to RUN with cyc=0, t=0.
  - start received in any other state is ignored.
- RUN, per tile:
  - act_rd_en = wet_rd_en = 1 for cyc 0..K-1.
  - act_rd_addr = act_base + cyc.
  - wet_rd_addr = wet_base + t*K + cyc, truncated to ADDR_W (wraps modulo 2^ADDR_W). Outside the read cycles both addresses are 0.
  - PE_clear_acc = 1 at cyc 0 only.
  - PE_mac_enable = 1 for cyc 1..K+1. The cyc-1 edge clears the accumulator. Edges at cyc 2..K+1 accumulate read steps 0..K-1 (2-cycle read-plus-register latency).
  - After cyc K+1, go to DRAIN.
- DRAIN: one cycle with PE_mac_enable=0, so the array output register loads the saturated result. Then go to OUT.
- OUT:
  - res_valid=1 and res_tile_idx=t; PE_mac_enable=0, so the result holds stable.
  - Stay in OUT while res_ready=0.
  - On res_valid & res_ready: if t==tile_num-1, go to DONE; else t=t+1 and go to RUN with cyc=0.
  - res_ready asserted outside OUT has no effect.
- DONE: done=1 for one cycle, then go to IDLE. busy is still 1 in DONE.
- PE_res_shift_num holds the latched cfg_shift from the start edge until the next accepted start, including in IDLE.
- Tile period with res_ready tied high is K+4 cycles. Job latency from the start edge to done is tile_num*(K+4)+1 cycles.

Test Plan:
- K=3, tiles=1, act_base=0x10, wet_base=0x20:
  - reads at 0x10/0x20, 0x11/0x21, 0x12/0x22;
  - clear in RUN cycle 0; mac_enable for 3+1 cycles starting cycle 1;
  - res_valid in cycle 7 after start; with ready high, done pulses in cycle 8.
- Same job against the real array with act=2 on all lanes, weights 1,2,3 and shift=0 -> every lane result equals 12 while res_valid is high.
- K=4, tiles=3, res_ready low for 5 cycles in tile 1 -> res_valid and res_tile_idx=1 are held, mac_enable stays 0, the array output stays unchanged, and tile 2 wet_rd_addr starts at wet_base+8.
- cfg_k_len=0 or cfg_tile_num=0 -> no rd_en and no mac_enable; done asserts the cycle after start.
- start pulsed while busy -> ignored, with configuration and addresses unchanged; wet_base=0xFFE, K=4 -> wet_rd_addr wraps 0xFFE, 0xFFF, 0x000, 0x001.
- reset_n asserted low during RUN cycle 2 -> all outputs 0 immediately, no done pulse; a new start then completes a correct tile with the first result uncorrupted.
